// File: rtl/alu_ctrl_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq_if
// Brief    : Upstream/downstream handshake and step-strobe bundle for alu_ctrl_seq.
// Revision : 1.0
// ============================================================================
interface alu_ctrl_seq_if #(
    parameter int FUNC_W    = 6,
    parameter int CTR_W     = 4,
    parameter int MC_CYCLES = 32
);
    localparam int c_CNT_W = $clog2(MC_CYCLES + 1);

    logic               in_valid;
    logic               in_ready;
    logic [2:0]         alu_op;
    logic [FUNC_W-1:0]  func;
    logic               out_valid;
    logic               out_ready;
    logic [CTR_W-1:0]   alu_ctr;
    logic               out_illegal;
    logic               out_multi;
    logic               mc_step;
    logic [c_CNT_W-1:0] mc_cnt;

    modport master (
        output in_valid, alu_op, func, out_ready,
        input  in_ready, out_valid, alu_ctr, out_illegal, out_multi, mc_step, mc_cnt
    );

    modport slave (
        input  in_valid, alu_op, func, out_ready,
        output in_ready, out_valid, alu_ctr, out_illegal, out_multi, mc_step, mc_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_seq
// Brief    : Registered ALU control decoder with valid/ready output stage and
//            MULT/DIV step sequencing.
// Revision : 1.0
// ============================================================================
module alu_ctrl_seq #(
    parameter int FUNC_W    = 6,
    parameter int CTR_W     = 4,
    parameter int MC_CYCLES = 32,
    parameter bit EN_MULTI  = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam int               c_CNT_W   = $clog2(MC_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MC_LOAD = c_CNT_W'(MC_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [3:0] c_AND  = 4'b0000;
    localparam logic [3:0] c_OR   = 4'b0001;
    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_XOR  = 4'b0011;
    localparam logic [3:0] c_NOR  = 4'b0100;
    localparam logic [3:0] c_SUB  = 4'b0110;
    localparam logic [3:0] c_SLT  = 4'b0111;
    localparam logic [3:0] c_SLL  = 4'b1000;
    localparam logic [3:0] c_SRL  = 4'b1001;
    localparam logic [3:0] c_MULT = 4'b1010;
    localparam logic [3:0] c_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_load_state;
    logic [FUNC_W-1:0]  w_func;
    logic [3:0]         w_dec_ctr;
    logic               w_dec_illegal;
    logic               w_dec_multi;
    logic [CTR_W-1:0]   w_ctr_ext;
    logic               w_in_ready;
    logic               w_accept;
    logic [CTR_W-1:0]   r_alu_ctr;
    logic               r_out_valid;
    logic               r_out_illegal;
    logic               r_out_multi;
    logic [c_CNT_W-1:0] r_mc_cnt;

    assign w_func = bus.func;

    always_comb begin
        w_dec_ctr     = c_ADD;
        w_dec_illegal = 1'b0;
        w_dec_multi   = 1'b0;
        case (bus.alu_op)
            3'b000: begin
                case (w_func[5:0])
                    6'b100000: w_dec_ctr = c_ADD;
                    6'b100010: w_dec_ctr = c_SUB;
                    6'b100100: w_dec_ctr = c_AND;
                    6'b100101: w_dec_ctr = c_OR;
                    6'b100110: w_dec_ctr = c_XOR;
                    6'b100111: w_dec_ctr = c_NOR;
                    6'b101010: w_dec_ctr = c_SLT;
                    6'b000000: w_dec_ctr = c_SLL;
                    6'b000010: w_dec_ctr = c_SRL;
                    6'b011000: begin w_dec_ctr = c_MULT; w_dec_multi = 1'b1; end
                    6'b011010: begin w_dec_ctr = c_DIV;  w_dec_multi = 1'b1; end
                    default:   w_dec_illegal = 1'b1;
                endcase
            end
            3'b001:  w_dec_ctr = c_ADD;
            3'b010:  w_dec_ctr = c_SUB;
            3'b011:  w_dec_ctr = c_AND;
            3'b100:  w_dec_ctr = c_OR;
            3'b101:  w_dec_ctr = c_SLT;
            3'b110:  w_dec_ctr = c_XOR;
            default: w_dec_illegal = 1'b1;
        endcase
        // Without the iterative unit, MULT/DIV fall back to the illegal encoding.
        if (w_dec_multi && !EN_MULTI) begin
            w_dec_ctr     = c_ADD;
            w_dec_illegal = 1'b1;
            w_dec_multi   = 1'b0;
        end
        w_ctr_ext      = '0;
        w_ctr_ext[3:0] = w_dec_ctr;
    end

    always_comb begin
        w_in_ready   = (r_state == S_IDLE) ||
                       (((r_state == S_HOLD) || (r_state == S_DONE)) && bus.out_ready);
        w_accept     = bus.in_valid && w_in_ready;
        w_load_state = w_dec_multi ? S_RUN : S_HOLD;
        w_state_nxt  = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_load_state;
            end
            S_HOLD, S_DONE: begin
                if (bus.out_ready) w_state_nxt = w_accept ? w_load_state : S_IDLE;
            end
            S_RUN: begin
                if (r_mc_cnt == c_CNT_ONE) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_alu_ctr     <= '0;
            r_out_illegal <= 1'b0;
            r_out_multi   <= 1'b0;
            r_mc_cnt      <= '0;
        end else begin
            r_out_valid <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_alu_ctr     <= w_ctr_ext;
                r_out_illegal <= w_dec_illegal;
                r_out_multi   <= w_dec_multi;
                r_mc_cnt      <= w_dec_multi ? c_MC_LOAD : '0;
            end else if (r_state == S_RUN) begin
                r_mc_cnt <= r_mc_cnt - c_CNT_ONE;
            end
        end
    end

    generate
        if (EN_MULTI) begin : g_multi
            assign bus.mc_step = (r_state == S_RUN);
        end else begin : g_no_multi
            assign bus.mc_step = 1'b0;
        end
    endgenerate

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.alu_ctr     = r_alu_ctr;
    assign bus.out_illegal = r_out_illegal;
    assign bus.out_multi   = r_out_multi;
    assign bus.mc_cnt      = r_mc_cnt;
endmodule
`default_nettype wire

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, handshaked successor to the combinational ALU control decoder in the miniMIPS datapath.
- Decodes the main-control alu_op and the full 6-bit R-type funct field into a 4-bit ALU control word, and registers it in a one-entry output stage with valid/ready handshakes.
- Sequences multi-cycle MULT/DIV operations: asserts a step strobe to the iterative unit for MC_CYCLES cycles and stalls upstream while doing so.

Parameters:
FUNC_W, 6, funct field width; must be >= 6; only bits [5:0] are decoded, upper bits ignored.
CTR_W, 4, ALU control word width; must be >= 4; upper bits are driven 0.
MC_CYCLES, 32, step cycles per MULT/DIV; must be >= 2.
EN_MULTI, 1, 1 = MULT/DIV supported; 0 = MULT/DIV decoded as illegal.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operation valid
in_ready  output  1  block accepts the operation this cycle
alu_op  input  3  main-control ALU operation class
func  input  FUNC_W  instruction funct field
out_valid  output  1  alu_ctr/flags valid for the ALU
out_ready  input  1  downstream consumes the output
alu_ctr  output  CTR_W  registered ALU control word
out_illegal  output  1  the presented operation decoded illegal
out_multi  output  1  the presented result came from MULT/DIV
mc_step  output  1  iterative-unit step strobe
mc_cnt  output  $clog2(MC_CYCLES+1)  remaining step count

Behaviour:
- Decode, combinational, applied to inputs at acceptance:
  - alu_op 001 -> ADD 0010; 010 -> SUB 0110; 011 -> AND 0000; 100 -> OR 0001; 101 -> SLT 0111; 110 -> XOR 0011; 111 -> illegal.
  - alu_op 000 selects on func[5:0]:
    - 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001.
    - 100110 XOR 0011; 100111 NOR 0100; 101010 SLT 0111.
    - 000000 SLL 1000; 000010 SRL 1001.
    - 011000 MULT 1010 (multi); 011010 DIV 1011 (multi).
    - Any other func is illegal.
  - Illegal operation: alu_ctr = ADD 0010, out_illegal = 1, treated as a single-cycle operation.
- Accept: in_valid & in_ready.
- in_ready = (state==IDLE) | ((state==HOLD | state==DONE) & out_ready). Combinational from state and out_ready only; never from in_valid.
- FSM states:
  - IDLE: out_valid = 0.
    - Accept single-cycle -> HOLD.
    - Accept multi -> RUN; mc_cnt loads MC_CYCLES.
  - HOLD: out_valid = 1; alu_ctr, out_illegal, out_multi held stable until out_ready.
    - out_ready & accept -> reload the output register and go to HOLD or RUN by the new operation's type. Throughput is 1 op/cycle.
    - out_ready without accept -> IDLE.
  - RUN: out_valid = 0; mc_step = 1 every cycle; alu_ctr already shows the MULT/DIV code; in_ready = 0.
    - mc_cnt decrements by 1 per cycle.
    - When mc_cnt == 1, the next state is DONE with mc_cnt = 0.
    - Exactly MC_CYCLES mc_step pulses are issued.
  - DONE: out_valid = 1, out_multi = 1. out_ready behaves as in HOLD.
- Latency:
  - Single-cycle: out_valid the cycle after acceptance.
  - Multi: out_valid MC_CYCLES+1 cycles after acceptance.
- Backpressure: while out_valid & !out_ready, all outputs are held unchanged and no operation is accepted.
- in_valid during RUN is ignored. Upstream must hold the operation; there is no loss because in_ready = 0.
- EN_MULTI = 0: MULT/DIV are illegal (alu_ctr 0010, out_illegal 1); RUN is unreachable and mc_step is constant 0.
- Reset (asynchronous, any state including mid-RUN):
  - state = IDLE.
  - alu_ctr = 0; out_valid, out_illegal, out_multi, mc_step = 0; mc_cnt = 0.
  - An aborted MULT/DIV produces no output.
- out_valid, alu_ctr, out_illegal, out_multi and mc_cnt are flop outputs. mc_step is decoded from state only.

Test Plan:
- Reset, then alu_op=000 func=100010 with out_ready=1 -> next cycle out_valid=1, alu_ctr=0110, out_illegal=0; following cycle out_valid=0.
- Back-to-back accepts: alu_op 001, 010, 011 on consecutive cycles with out_ready=1 -> alu_ctr 0010, 0110, 0000 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles after an OR (alu_op 100) -> alu_ctr=0001 held, in_ready=0; release -> next operation accepted in the same cycle.
- MULT func=011000 with MC_CYCLES=4 -> in_ready=0 and exactly 4 mc_step pulses with mc_cnt 4,3,2,1; then out_valid=1, alu_ctr=1010, out_multi=1.
- Illegal inputs: alu_op=111, and alu_op=000 func=111111 -> alu_ctr=0010, out_illegal=1. With EN_MULTI=0, func=011010 -> out_illegal=1 and no mc_step.
- rst_n low at the 2nd mc_step of a DIV -> immediately all outputs 0 and state IDLE; after release, a new ADD yields 0010 with no stale DONE.
